// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command dispatcher.
// Contents: FSM state encoding, error codes, reg0 field positions,
// status-word bit positions and a helper that packs status word ro0.
package spi_cmd_pkg;

    typedef enum logic [1:0] {StIdle, StWait, StDone} cmdStateT;

    localparam logic [7:0] ERR_OK      = 8'd0;
    localparam logic [7:0] ERR_BADENG  = 8'd1;
    localparam logic [7:0] ERR_TIMEOUT = 8'd2;

    // Command word reg0 layout
    localparam int unsigned ENG_MSB = 31;
    localparam int unsigned ENG_LSB = 28;
    localparam int unsigned OP_MSB  = 27;
    localparam int unsigned OP_LSB  = 8;
    localparam int unsigned TAG_MSB = 7;
    localparam int unsigned TAG_LSB = 0;

    // Status word ro0 layout
    localparam int unsigned STS_TAG_LSB  = 0;
    localparam int unsigned STS_ERR_LSB  = 8;
    localparam int unsigned STS_BUSY_BIT = 16;
    localparam int unsigned STS_OVR_BIT  = 17;

    function automatic logic [31:0] packStatus(input logic [7:0] tag, input logic [7:0] err,
                                               input logic busy, input logic ovr);
        logic [31:0] w;
        w = '0;
        w[STS_TAG_LSB +: 8] = tag;
        w[STS_ERR_LSB +: 8] = err;
        w[STS_BUSY_BIT]     = busy;
        w[STS_OVR_BIT]      = ovr;
        return w;
    endfunction

endpackage

// File: rtl/spi_cmd_dispatch_if.sv
// Engine-side request/done bus of the command dispatcher.
// master: dispatcher (drives engReq/engOp/engArgs, receives engDone/engResult).
// slave:  engine array.
//   engReq    one-hot level request, at most one bit set
//   engOp     20-bit opcode/argument field of the latched command
//   engArgs   latched argument words {reg3, reg2, reg1}
//   engDone   per-engine single-cycle completion pulse
//   engResult per-engine 32-bit result, engine e at [32e+31:32e]
interface spi_cmd_dispatch_if #(
    parameter int unsigned nrEngines = 4
);
    logic [nrEngines-1:0]    engReq;
    logic [19:0]             engOp;
    logic [95:0]             engArgs;
    logic [nrEngines-1:0]    engDone;
    logic [nrEngines*32-1:0] engResult;

    modport master (output engReq, engOp, engArgs, input engDone, engResult);
    modport slave  (input engReq, engOp, engArgs, output engDone, engResult);
endinterface

// File: rtl/spi_cmd_timer.sv
// Elapsed-cycle counter for one dispatched command.
//   sysClk/usrReset  clock, synchronous active-high reset
//   clr              zero the count (new command accepted)
//   en               advance the count by one
//   count            elapsed cycles, saturating at 2^32-1
//   atTimeout        count has reached TIMEOUT-1
module spi_cmd_timer #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic        sysClk,
    input  logic        usrReset,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] count,
    output logic        atTimeout
);
    localparam logic [31:0] LastCount = 32'(TIMEOUT - 1);

    always_ff @(posedge sysClk) begin
        if (usrReset || clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 32'd1;
        end
    end

    assign atTimeout = (count == LastCount);
endmodule

// File: rtl/spi_cmd_dispatch.sv
// Command scheduler between the SPI RW register block and nrEngines engines.
// A command is accepted when the tag byte of reg0 differs from the last accepted
// tag; it is dispatched over a req/done handshake with a timeout, and the outcome
// is reported in three status words.
//   sysClk/usrReset  clock, synchronous active-high reset
//   rwRegs1D         flattened host RW registers, word n at [32n+31:32n]
//   eng              engine bus (master side)
//   stsRegs1D        status {ro2 cycles, ro1 result, ro0 tag/err/busy/overrun}
module spi_cmd_dispatch
    import spi_cmd_pkg::*;
#(
    parameter int unsigned nrRWregs  = 4,
    parameter int unsigned nrEngines = 4,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                  sysClk,
    input  logic                  usrReset,
    input  logic [nrRWregs*32-1:0] rwRegs1D,
    spi_cmd_dispatch_if.master    eng,
    output logic [95:0]           stsRegs1D
);
    logic [31:0]          reg0;
    logic [3:0]           cmdEng;
    logic [7:0]           cmdTag;
    logic                 tagChanged, badEng, accept, doneSel, timerEn, atTimeout;
    logic [nrEngines-1:0] oneHot;
    logic [31:0]          selResult, elapsed, elapsedPlus1;

    cmdStateT             state;
    logic [7:0]           lastTag, errQ, pendErr, doneTagQ;
    logic [19:0]          opQ;
    logic [95:0]          argsQ;
    logic [nrEngines-1:0] reqQ;
    logic [31:0]          resultQ, pendResult, cyclesQ;
    logic                 busyQ, ovrQ;

    assign reg0       = rwRegs1D[31:0];
    assign cmdEng     = reg0[ENG_MSB:ENG_LSB];
    assign cmdTag     = reg0[TAG_MSB:TAG_LSB];
    assign tagChanged = (cmdTag != lastTag);
    assign badEng     = (32'(cmdEng) >= nrEngines);
    assign accept     = (state == StIdle) && tagChanged;

    // reqQ doubles as the engine select while waiting, so no id indexing is needed
    assign doneSel = |(eng.engDone & reqQ);

    always_comb begin
        oneHot    = '0;
        selResult = '0;
        for (int e = 0; e < int'(nrEngines); e++) begin
            oneHot[e] = (cmdEng == 4'(e));
            if (reqQ[e]) selResult = eng.engResult[32*e +: 32];
        end
    end

    // The count freezes on the finishing cycle; the report adds that cycle back
    assign timerEn      = (state == StWait) && !doneSel && !atTimeout;
    assign elapsedPlus1 = (elapsed == '1) ? elapsed : elapsed + 32'd1;

    spi_cmd_timer #(
        .TIMEOUT (TIMEOUT)
    ) uTimer (
        .sysClk    (sysClk),
        .usrReset  (usrReset),
        .clr       (accept),
        .en        (timerEn),
        .count     (elapsed),
        .atTimeout (atTimeout)
    );

    always_ff @(posedge sysClk) begin
        if (usrReset) begin
            state      <= StIdle;
            lastTag    <= '0;
            opQ        <= '0;
            argsQ      <= '0;
            reqQ       <= '0;
            pendErr    <= ERR_OK;
            pendResult <= '0;
            doneTagQ   <= '0;
            errQ       <= ERR_OK;
            resultQ    <= '0;
            cyclesQ    <= '0;
            busyQ      <= 1'b0;
            ovrQ       <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (tagChanged) begin
                        opQ     <= reg0[OP_MSB:OP_LSB];
                        argsQ   <= rwRegs1D[127:32];
                        lastTag <= cmdTag;
                        busyQ   <= 1'b1;
                        ovrQ    <= 1'b0;
                        if (badEng) begin
                            pendErr    <= ERR_BADENG;
                            pendResult <= '0;
                            state      <= StDone;
                        end else begin
                            reqQ  <= oneHot;
                            state <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (doneSel) begin
                        pendResult <= selResult;
                        pendErr    <= ERR_OK;
                        reqQ       <= '0;
                        state      <= StDone;
                    end else if (atTimeout) begin
                        pendResult <= '0;
                        pendErr    <= ERR_TIMEOUT;
                        reqQ       <= '0;
                        state      <= StDone;
                    end
                end
                StDone: begin
                    doneTagQ <= lastTag;
                    errQ     <= pendErr;
                    resultQ  <= pendResult;
                    cyclesQ  <= elapsedPlus1;
                    busyQ    <= 1'b0;
                    state    <= StIdle;
                end
                default: state <= StIdle;
            endcase
            // A newer tag while busy is flagged; IDLE picks up the latest one later
            if ((state != StIdle) && tagChanged) ovrQ <= 1'b1;
        end
    end

    assign eng.engReq  = reqQ;
    assign eng.engOp   = opQ;
    assign eng.engArgs = argsQ;
    assign stsRegs1D   = {cyclesQ, resultQ, packStatus(doneTagQ, errQ, busyQ, ovrQ)};
endmodule
